// File: rtl/arkanoid_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arkanoid_input_pkg
// Description : Shared definitions for the Arkanoid spinner input path:
//               quadrature codes, forward/reverse Gray next-state tables,
//               pending-position width and saturation limits.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package arkanoid_input_pkg;

  // Pending position: signed, symmetric limits so negation never overflows.
  localparam int                     c_pos_w   = 12;
  localparam logic signed [11:0]     c_pos_max = 12'sd2047;
  localparam logic signed [11:0]     c_pos_min = -12'sd2047;

  typedef enum logic [1:0] {
    QUAD_00 = 2'b00,
    QUAD_01 = 2'b01,
    QUAD_10 = 2'b10,
    QUAD_11 = 2'b11
  } quad_t;

  localparam quad_t c_quad_reset = QUAD_11;

  // Forward rotation: 00 -> 10 -> 11 -> 01 -> 00
  function automatic quad_t quad_fwd(input quad_t q);
    case (q)
      QUAD_00: quad_fwd = QUAD_10;
      QUAD_10: quad_fwd = QUAD_11;
      QUAD_11: quad_fwd = QUAD_01;
      default: quad_fwd = QUAD_00;
    endcase
  endfunction

  // Reverse rotation: 00 -> 01 -> 11 -> 10 -> 00
  function automatic quad_t quad_rev(input quad_t q);
    case (q)
      QUAD_00: quad_rev = QUAD_01;
      QUAD_01: quad_rev = QUAD_11;
      QUAD_11: quad_rev = QUAD_10;
      default: quad_rev = QUAD_00;
    endcase
  endfunction

  // Clamp a one-bit-wider sum back into the symmetric position range.
  function automatic logic signed [11:0] pos_sat(input logic signed [12:0] v);
    if (v > 13'sd2047)
      pos_sat = c_pos_max;
    else if (v < -13'sd2047)
      pos_sat = c_pos_min;
    else
      pos_sat = v[11:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : quad_sequencer
// Description : Two-bit Gray-code quadrature generator. Advances one code per
//               asserted step, forward when dir=1, reverse when dir=0.
// Ports       : clk_6m  - clock (rising edge)
//               reset   - asynchronous active-low reset (state -> 2'b11)
//               step    - advance one Gray step this cycle
//               dir     - 1 = forward, 0 = reverse
//               state   - current AB quadrature code
// Revision    : 1.0 - initial release
// ============================================================================
module quad_sequencer
  import arkanoid_input_pkg::*;
(
  input  logic       clk_6m,
  input  logic       reset,
  input  logic       step,
  input  logic       dir,
  output logic [1:0] state
);

  quad_t state_q;
  quad_t state_d;

  always_comb begin
    state_d = state_q;
    if (step)
      state_d = dir ? quad_fwd(state_q) : quad_rev(state_q);
  end

  always_ff @(posedge clk_6m or negedge reset) begin
    if (!reset)
      state_q <= c_quad_reset;
    else
      state_q <= state_d;
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/mouse_spinner.sv
`default_nettype none
// ============================================================================
// Module      : mouse_spinner
// Description : Converts PS/2 mouse X deltas and digital joystick left/right
//               into AB quadrature for the Arkanoid spinner input. A signed
//               pending position is accumulated from packets/joystick and
//               paid out one quadrature step per step-divider tick.
// Ports       : clk_6m       - clock (rising edge)
//               reset        - asynchronous active-low reset
//               mouse_toggle - packet strobe; every level change = new packet
//               mouse_dx     - signed 9-bit X delta of current packet
//               joy_right    - digital right (active-high)
//               joy_left     - digital left (active-high)
//               joy_fast     - use JOY_FAST magnitude instead of JOY_SLOW
//               spinner      - AB quadrature output
//               busy         - registered (pending position != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_spinner
  import arkanoid_input_pkg::*;
#(
  parameter int STEP_DIV   = 375,
  parameter int JOY_PERIOD = 48000,
  parameter int JOY_SLOW   = 4,
  parameter int JOY_FAST   = 9
) (
  input  logic       clk_6m,
  input  logic       reset,
  input  logic       mouse_toggle,
  input  logic [8:0] mouse_dx,
  input  logic       joy_right,
  input  logic       joy_left,
  input  logic       joy_fast,
  output logic [1:0] spinner,
  output logic       busy
);

  localparam int DIV_W = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
  localparam int JOY_W = (JOY_PERIOD > 1) ? $clog2(JOY_PERIOD) : 1;

  localparam logic [DIV_W-1:0]   c_div_last = DIV_W'(STEP_DIV - 1);
  localparam logic [JOY_W-1:0]   c_joy_last = JOY_W'(JOY_PERIOD - 1);
  localparam logic signed [11:0] c_joy_slow = 12'(JOY_SLOW);
  localparam logic signed [11:0] c_joy_fast = 12'(JOY_FAST);

  logic                toggle_q, toggle_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [JOY_W-1:0]    joy_q, joy_d;
  logic signed [11:0]  pos_q, pos_d;
  logic                busy_q, busy_d;

  logic                step_tick;
  logic                packet;
  logic                step_en;
  logic                step_dir;
  logic                joy_active;
  logic                joy_load;
  logic signed [11:0]  step_pos;
  logic signed [11:0]  dx_ext;
  logic signed [11:0]  joy_mag;
  logic signed [12:0]  sum;

  always_comb begin
    step_tick  = (div_q == c_div_last);
    packet     = (mouse_toggle != toggle_q);
    toggle_d   = mouse_toggle;
    div_d      = step_tick ? '0 : div_q + DIV_W'(1);

    // Steps only pay out a non-zero position; direction follows its sign.
    step_en    = step_tick && (pos_q != 12'sd0);
    step_dir   = !pos_q[11];

    step_pos   = pos_q;
    if (step_en)
      step_pos = step_dir ? pos_q - 12'sd1 : pos_q + 12'sd1;

    // Packet evaluated against the already-stepped position. Sign is taken
    // from the sign bits, so dx=0 counts as non-negative.
    dx_ext     = {{3{mouse_dx[8]}}, mouse_dx};
    sum        = {step_pos[11], step_pos} + {dx_ext[11], dx_ext};
    pos_d      = step_pos;
    if (packet) begin
      if ((step_pos == 12'sd0) || (step_pos[11] == mouse_dx[8]))
        pos_d = pos_sat(sum);
      else
        pos_d = dx_ext;
    end

    joy_active = joy_right || joy_left;
    joy_load   = joy_active && (joy_q == c_joy_last);
    joy_d      = (joy_active && !joy_load) ? joy_q + JOY_W'(1) : '0;
    joy_mag    = joy_fast ? c_joy_fast : c_joy_slow;
    // Joystick load wins over any packet/step result for the position.
    if (joy_load)
      pos_d = joy_right ? joy_mag : -joy_mag;

    busy_d     = (pos_q != 12'sd0);
  end

  always_ff @(posedge clk_6m or negedge reset) begin
    if (!reset) begin
      toggle_q <= 1'b0;
      div_q    <= '0;
      joy_q    <= '0;
      pos_q    <= 12'sd0;
      busy_q   <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      div_q    <= div_d;
      joy_q    <= joy_d;
      pos_q    <= pos_d;
      busy_q   <= busy_d;
    end
  end

  quad_sequencer u_quad_sequencer (
    .clk_6m (clk_6m),
    .reset  (reset),
    .step   (step_en),
    .dir    (step_dir),
    .state  (spinner)
  );

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_spinner.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_spinner
// Description : Self-checking bench for mouse_spinner against a cycle-level
//               behavioural model (integer position, rotation angle index).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_spinner;

  localparam int STEP_DIV   = 6;
  localparam int JOY_PERIOD = 40;
  localparam int JOY_SLOW   = 4;
  localparam int JOY_FAST   = 9;

  logic       clk_6m = 1'b0;
  logic       reset = 1'b0;
  logic       mouse_toggle = 1'b0;
  logic [8:0] mouse_dx = '0;
  logic       joy_right = 1'b0;
  logic       joy_left = 1'b0;
  logic       joy_fast = 1'b0;
  logic [1:0] spinner;
  logic       busy;

  int checks = 0;
  int failures = 0;

  mouse_spinner #(
    .STEP_DIV   (STEP_DIV),
    .JOY_PERIOD (JOY_PERIOD),
    .JOY_SLOW   (JOY_SLOW),
    .JOY_FAST   (JOY_FAST)
  ) dut (
    .clk_6m       (clk_6m),
    .reset        (reset),
    .mouse_toggle (mouse_toggle),
    .mouse_dx     (mouse_dx),
    .joy_right    (joy_right),
    .joy_left     (joy_left),
    .joy_fast     (joy_fast),
    .spinner      (spinner),
    .busy         (busy)
  );

  always #5 clk_6m = ~clk_6m;

  // ---- behavioural model ------------------------------------------------
  // Rotation is an angle index 0..3 into the forward code order.
  int m_pos   = 0;
  int m_angle = 2;     // code 11
  int m_div   = 0;
  int m_joy   = 0;
  bit m_tog   = 1'b0;
  bit m_busy  = 1'b0;
  bit m_load  = 1'b0;

  function automatic logic [1:0] code_of(input int a);
    logic [1:0] codes [4];
    codes = '{2'b00, 2'b10, 2'b11, 2'b01};
    return codes[a % 4];
  endfunction

  function automatic int angle_of(input logic [1:0] c);
    for (int i = 0; i < 4; i++)
      if (code_of(i) == c) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_angle = 2; m_div = 0; m_joy = 0;
    m_tog = 1'b0; m_busy = 1'b0; m_load = 1'b0;
  endtask

  // Advance model by one clock using the current inputs, then move to #1
  // past the rising edge.
  task automatic tick();
    int  p, dx, mag;
    bit  st, pk;
    if (!reset) begin
      model_reset();
    end else begin
      st = (m_div == STEP_DIV - 1);
      pk = (mouse_toggle != m_tog);
      p  = m_pos;
      if (st && p > 0) begin p = p - 1; m_angle = (m_angle + 1) % 4; end
      else if (st && p < 0) begin p = p + 1; m_angle = (m_angle + 3) % 4; end
      if (pk) begin
        dx = int'($signed(mouse_dx));
        if (p == 0 || ((p < 0) == (dx < 0))) begin
          p = p + dx;
          if (p > 2047) p = 2047;
          if (p < -2047) p = -2047;
        end else begin
          p = dx;
        end
      end
      m_load = (joy_right || joy_left) && (m_joy == JOY_PERIOD - 1);
      if (m_load) begin
        mag = joy_fast ? JOY_FAST : JOY_SLOW;
        p = joy_right ? mag : -mag;
      end
      m_busy = (m_pos != 0);
      m_joy  = (joy_right || joy_left) ? (m_load ? 0 : m_joy + 1) : 0;
      m_div  = st ? 0 : m_div + 1;
      m_tog  = mouse_toggle;
      m_pos  = p;
    end
    @(posedge clk_6m);
    #1;
  endtask

  task automatic send_packet(input int dx);
    mouse_dx     = 9'(dx);
    mouse_toggle = ~mouse_toggle;
    tick();
  endtask

  // ---- tests ------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (spinner !== 2'b11) begin failures++;
      $display("FAIL reset_spinner got=%b exp=11", spinner); end
    checks++;
    if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (dut.pos_q !== 12'sd0) begin failures++;
      $display("FAIL reset_pos got=%0d exp=0", $signed(dut.pos_q)); end
    reset = 1'b1;
  endtask

  task automatic test_packet_steps();
    logic [1:0] prev;
    logic [1:0] seen [$];
    send_packet(3);
    prev = spinner;
    for (int i = 0; i < 4 * STEP_DIV; i++) begin
      checks++;
      if (spinner !== code_of(m_angle) || busy !== m_busy || dut.pos_q !== 12'(m_pos)) begin
        failures++;
        $display("FAIL pkt3_cycle spinner=%b/%b busy=%b/%b pos=%0d/%0d",
                 spinner, code_of(m_angle), busy, m_busy, $signed(dut.pos_q), m_pos);
      end
      if (spinner !== prev) begin seen.push_back(spinner); prev = spinner; end
      tick();
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 2'b01 || seen[1] !== 2'b00 || seen[2] !== 2'b10) begin
      failures++;
      $display("FAIL pkt3_sequence got_changes=%0d last=%b exp=01,00,10", seen.size(), spinner);
    end
    checks++;
    if (busy !== 1'b0) begin failures++;
      $display("FAIL pkt3_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_reverse();
    logic [1:0] prev;
    logic [1:0] seen [$];
    send_packet(5);
    send_packet(-2);
    checks++;
    if (dut.pos_q !== -12'sd2) begin failures++;
      $display("FAIL rev_replace got=%0d exp=-2", $signed(dut.pos_q)); end
    prev = spinner;
    for (int i = 0; i < 3 * STEP_DIV; i++) begin
      checks++;
      if (spinner !== code_of(m_angle) || dut.pos_q !== 12'(m_pos)) begin failures++;
        $display("FAIL rev_cycle spinner=%b/%b pos=%0d/%0d",
                 spinner, code_of(m_angle), $signed(dut.pos_q), m_pos); end
      if (spinner !== prev) begin seen.push_back(spinner); prev = spinner; end
      tick();
    end
    checks++;
    if (seen.size() != 2 || seen[0] !== 2'b00 || seen[1] !== 2'b01) begin failures++;
      $display("FAIL rev_sequence got_changes=%0d last=%b exp=00,01", seen.size(), spinner); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      send_packet(255);
      checks++;
      if (dut.pos_q !== 12'(m_pos) || $signed(dut.pos_q) < 0) begin failures++;
        $display("FAIL sat_pos_step%0d got=%0d exp=%0d", i, $signed(dut.pos_q), m_pos); end
    end
    checks++;
    if (dut.pos_q !== 12'sd2047) begin failures++;
      $display("FAIL sat_pos_max got=%0d exp=2047", $signed(dut.pos_q)); end
    for (int i = 0; i < 10; i++) send_packet(-255);
    checks++;
    if (dut.pos_q !== -12'sd2047) begin failures++;
      $display("FAIL sat_neg_min got=%0d exp=-2047", $signed(dut.pos_q)); end
  endtask

  task automatic test_joystick();
    int loads = 0;
    joy_right = 1'b1; joy_fast = 1'b1;
    for (int i = 0; i < 2 * JOY_PERIOD; i++) begin
      tick();
      if (m_load) begin
        loads++;
        checks++;
        if (dut.pos_q !== 12'sd9) begin failures++;
          $display("FAIL joy_fast_load got=%0d exp=9", $signed(dut.pos_q)); end
      end
    end
    checks++;
    if (loads != 2) begin failures++;
      $display("FAIL joy_load_count got=%0d exp=2", loads); end
    repeat (JOY_PERIOD / 2) tick();
    joy_right = 1'b0;
    tick();
    checks++;
    if (dut.joy_q !== '0 || dut.pos_q !== 12'(m_pos)) begin failures++;
      $display("FAIL joy_release cnt=%0d pos=%0d exp cnt=0 pos=%0d",
               dut.joy_q, $signed(dut.pos_q), m_pos); end
    joy_left = 1'b1; joy_fast = 1'b0;
    repeat (JOY_PERIOD) tick();
    checks++;
    if (dut.pos_q !== -12'sd4) begin failures++;
      $display("FAIL joy_left_slow got=%0d exp=-4", $signed(dut.pos_q)); end
    joy_left = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [1:0] prev;
    for (int i = 0; i < 20 * STEP_DIV && m_pos != 0; i++) tick();
    send_packet(1);
    for (int i = 0; i < STEP_DIV && m_div != STEP_DIV - 1; i++) tick();
    checks++;
    if (dut.pos_q !== 12'sd1) begin failures++;
      $display("FAIL same_setup_pos got=%0d exp=1", $signed(dut.pos_q)); end
    prev = spinner;
    send_packet(4);
    checks++;
    if (dut.pos_q !== 12'sd4) begin failures++;
      $display("FAIL same_cycle_pos got=%0d exp=4", $signed(dut.pos_q)); end
    checks++;
    if (spinner !== code_of(angle_of(prev) + 1)) begin failures++;
      $display("FAIL same_cycle_step got=%b exp=%b", spinner, code_of(angle_of(prev) + 1)); end
  endtask

  task automatic test_reset_midstep();
    send_packet(50);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    mouse_toggle = 1'b0;
    #1;
    model_reset();
    checks++;
    if (spinner !== 2'b11 || busy !== 1'b0 || dut.pos_q !== 12'sd0) begin failures++;
      $display("FAIL midreset_immediate spinner=%b busy=%b pos=%0d exp 11/0/0",
               spinner, busy, $signed(dut.pos_q)); end
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 3 * STEP_DIV; i++) begin
      tick();
      checks++;
      if (spinner !== 2'b11 || busy !== 1'b0) begin failures++;
        $display("FAIL midreset_hold spinner=%b busy=%b exp 11/0", spinner, busy); end
    end
  endtask

  task automatic test_random();
    logic [1:0] prev;
    int dx, sel;
    prev = spinner;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        dx = int'($urandom_range(0, 510)) - 255;
        if (dx == 0) dx = 1;
        mouse_dx = 9'(dx);
        mouse_toggle = ~mouse_toggle;
      end
      if ($urandom_range(0, 60) == 0) begin
        sel = int'($urandom_range(0, 3));
        joy_right = sel[0]; joy_left = sel[1];
        joy_fast = 1'($urandom_range(0, 1));
      end
      tick();
      checks++;
      if (spinner !== code_of(m_angle) || busy !== m_busy || dut.pos_q !== 12'(m_pos) ||
          $countones(spinner ^ prev) > 1) begin
        failures++;
        $display("FAIL random_cycle%0d spinner=%b/%b busy=%b/%b pos=%0d/%0d",
                 i, spinner, code_of(m_angle), busy, m_busy, $signed(dut.pos_q), m_pos);
      end
      prev = spinner;
    end
    joy_right = 1'b0; joy_left = 1'b0;
  endtask

  initial begin
    test_reset();
    test_packet_steps();
    test_reverse();
    test_back_to_back();
    test_joystick();
    test_same_cycle();
    test_reset_midstep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
